// File: rtl/seq_divider.sv
// Sequential signed fixed-point divider: R = trunc(error * 2^REMAINDER_SIZE / reference).
// Optional saturation of the single overflow case (-2^(N-1) / -1) via `SEQ_DIVIDER_SATURATE_EN.
module seq_divider #(
    parameter int DATA_SIZE      = 14,
    parameter int REMAINDER_SIZE = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic signed [DATA_SIZE-1:0] i_error,
    input  logic signed [DATA_SIZE-1:0] i_reference,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic signed [DATA_SIZE-1:0] o_quotient,
    output logic [REMAINDER_SIZE-1:0]   o_remainder,
    output logic                        o_valid,
    output logic                        o_div_by_zero,
    output logic                        o_overflow
);

    localparam int RES_SIZE = DATA_SIZE + REMAINDER_SIZE;
    localparam int CNT_SIZE = $clog2(RES_SIZE);
    localparam logic [CNT_SIZE-1:0] LAST_ITER = CNT_SIZE'(RES_SIZE - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t state, next_state;

    logic [RES_SIZE-1:0]  num;
    logic [DATA_SIZE-1:0] rem;
    logic [DATA_SIZE-1:0] dmag;
    logic                 neg;
    logic [CNT_SIZE-1:0]  count;
    logic [RES_SIZE-1:0]  res;
    logic                 dbz;

    logic                 divisor_zero;
    logic [DATA_SIZE-1:0] error_mag;
    logic [DATA_SIZE-1:0] ref_mag;
    logic [RES_SIZE-1:0]  zero_div_res;
    logic [DATA_SIZE:0]   trial;
    logic [DATA_SIZE:0]   diff;
    logic                 take;

    assign divisor_zero = (i_reference == '0);
    // Magnitudes are unsigned, so the most negative operand negates to itself and stays exact.
    assign error_mag    = i_error[DATA_SIZE-1]     ? $unsigned(-i_error)     : $unsigned(i_error);
    assign ref_mag      = i_reference[DATA_SIZE-1] ? $unsigned(-i_reference) : $unsigned(i_reference);
    assign zero_div_res = {i_error[DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                                : {1'b0, {(DATA_SIZE-1){1'b1}}},
                           {REMAINDER_SIZE{1'b0}}};

    assign trial = {rem, num[RES_SIZE-1]};
    assign diff  = trial - {1'b0, dmag};
    assign take  = ~diff[DATA_SIZE];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_start) next_state = divisor_zero ? DONE : CALC;
            CALC: if (count == LAST_ITER) next_state = SIGN;
            SIGN: next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The numerator register doubles as the quotient: each iteration shifts a result bit in at the LSB.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            num   <= '0;
            rem   <= '0;
            dmag  <= '0;
            neg   <= 1'b0;
            count <= '0;
            res   <= '0;
            dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SATURATE_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    num   <= {error_mag, {REMAINDER_SIZE{1'b0}}};
                    rem   <= '0;
                    dmag  <= ref_mag;
                    neg   <= i_error[DATA_SIZE-1] ^ i_reference[DATA_SIZE-1];
                    count <= '0;
                    if (divisor_zero) begin
                        res <= zero_div_res;
                        dbz <= 1'b1;
`ifdef SEQ_DIVIDER_SATURATE_EN
                        o_overflow <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    num   <= {num[RES_SIZE-2:0], take};
                    rem   <= take ? diff[DATA_SIZE-1:0] : trial[DATA_SIZE-1:0];
                    count <= count + CNT_SIZE'(1);
                end
                SIGN: begin
                    dbz <= 1'b0;
`ifdef SEQ_DIVIDER_SATURATE_EN
                    // A positive magnitude with the top bit set can only come from -2^(N-1) / -1.
                    if (!neg && num[RES_SIZE-1]) begin
                        res        <= {1'b0, {(RES_SIZE-1){1'b1}}};
                        o_overflow <= 1'b1;
                    end else begin
                        res        <= neg ? -num : num;
                        o_overflow <= 1'b0;
                    end
`else
                    res <= neg ? -num : num;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef SEQ_DIVIDER_SATURATE_EN
    assign o_overflow = 1'b0;
`endif

    assign o_busy        = (state != IDLE);
    assign o_valid       = (state == DONE);
    assign o_quotient    = res[RES_SIZE-1 -: DATA_SIZE];
    assign o_remainder   = res[REMAINDER_SIZE-1:0];
    assign o_div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at default parameters (14.8 fixed point).
module tb_seq_divider;

    logic               clk;
    logic               rst;
    logic signed [13:0] error_in;
    logic signed [13:0] reference_in;
    logic               start;
    logic               busy;
    logic signed [13:0] quotient;
    logic [7:0]         remainder;
    logic               valid;
    logic               div_by_zero;
    logic               overflow;

    int assert_count = 0;
    int fail_count   = 0;
    int cycles;
    int valid_seen;

    seq_divider dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_error      (error_in),
        .i_reference  (reference_in),
        .i_start      (start),
        .o_busy       (busy),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_valid      (valid),
        .o_div_by_zero(div_by_zero),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one start pulse across the next rising edge, then scrambles the operands.
    task automatic applyStimulus(input logic signed [13:0] err, input logic signed [13:0] ref_val);
        error_in     = err;
        reference_in = ref_val;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        error_in     = 14'sd1;
        reference_in = 14'sd0;
    endtask

    task automatic waitValid(input int budget, output int lat);
        lat = 1;
        while (!valid && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkResult(input string tag, input int lat_exp, input logic [13:0] q_exp,
                               input logic [7:0] r_exp, input logic dbz_exp, input logic ovf_exp);
        int lat;
        waitValid(40, lat);
        checkOutput({tag, "_latency"}, lat, lat_exp);
        checkOutput({tag, "_valid"}, valid, 1'b1);
        checkOutput({tag, "_quotient"}, $unsigned(quotient), q_exp);
        checkOutput({tag, "_remainder"}, remainder, r_exp);
        checkOutput({tag, "_div_by_zero"}, div_by_zero, dbz_exp);
        checkOutput({tag, "_overflow"}, overflow, ovf_exp);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_pulse"}, valid, 1'b0);
        checkOutput({tag, "_idle"}, busy, 1'b0);
        checkOutput({tag, "_hold"}, $unsigned(quotient), q_exp);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        error_in     = '0;
        reference_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_quotient", $unsigned(quotient), 14'h0);
        checkOutput("reset_remainder", remainder, 8'h0);
        checkOutput("reset_flags", {div_by_zero, overflow}, 2'b00);

        // Start on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(14'sd100, 14'sd7);
        checkOutput("pos_busy", busy, 1'b1);
        checkResult("pos", 24, 14'd14, 8'h49, 1'b0, 1'b0);

        applyStimulus(-14'sd100, 14'sd7);
        checkResult("negdividend", 24, 14'h3FF1, 8'hB7, 1'b0, 1'b0);

        applyStimulus(14'sd100, -14'sd7);
        checkResult("negdivisor", 24, 14'h3FF1, 8'hB7, 1'b0, 1'b0);

        applyStimulus(-14'sd100, -14'sd7);
        checkResult("bothneg", 24, 14'd14, 8'h49, 1'b0, 1'b0);

        applyStimulus(14'sd0, 14'sd5);
        checkResult("zerodividend", 24, 14'h0, 8'h00, 1'b0, 1'b0);

        applyStimulus(14'sd50, 14'sd0);
        checkResult("divzero_pos", 1, 14'h1FFF, 8'h00, 1'b1, 1'b0);

        applyStimulus(-14'sd50, 14'sd0);
        checkResult("divzero_neg", 1, 14'h2000, 8'h00, 1'b1, 1'b0);

`ifdef SEQ_DIVIDER_SATURATE_EN
        applyStimulus(-14'sd8192, -14'sd1);
        checkResult("overflow", 24, 14'h1FFF, 8'hFF, 1'b0, 1'b1);
`else
        applyStimulus(-14'sd8192, -14'sd1);
        checkResult("overflow", 24, 14'h2000, 8'h00, 1'b0, 1'b0);
`endif

        applyStimulus(-14'sd8192, 14'sd1);
        checkResult("minbyone", 24, 14'h2000, 8'h00, 1'b0, 1'b0);

        applyStimulus(14'sd8191, 14'sd3);
        checkResult("maxbythree", 24, 14'd2730, 8'h55, 1'b0, 1'b0);

        // A second start while busy must be ignored.
        applyStimulus(14'sd100, 14'sd7);
        cycles = 1;
        while (!valid && cycles < 40) begin
            if (cycles == 4) begin
                error_in     = 14'sd1;
                reference_in = 14'sd1;
                start        = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        checkOutput("ignored_latency", cycles, 24);
        checkOutput("ignored_quotient", $unsigned(quotient), 14'd14);
        checkOutput("ignored_remainder", remainder, 8'h49);
        @(posedge clk);
        #1;
        checkOutput("ignored_single_valid", valid, 1'b0);
        applyStimulus(14'sd1, 14'sd1);
        checkOutput("backtoback_busy", busy, 1'b1);
        checkResult("backtoback", 24, 14'd1, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a division aborts it.
        applyStimulus(14'sd100, 14'sd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_quotient", $unsigned(quotient), 14'h0);
        checkOutput("abort_remainder", remainder, 8'h00);
        checkOutput("abort_valid", valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        valid_seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid) valid_seen++;
        end
        checkOutput("abort_no_valid", valid_seen, 0);
        applyStimulus(-14'sd100, 14'sd7);
        checkResult("after_abort", 24, 14'h3FF1, 8'hB7, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
